calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Sequencer for the double-eye correlation datapath (topcalcunit). On one `go` pulse it sweeps a run of candidate disparity places, streams a WIN-sample window of f/g pixel pairs through the unit for each place, waits for the 18-bit `result` to settle, and keeps the best (result, place) pair. It sits between the pixel line buffer, which supplies `fdata`/`gdata` directly to the unit, and the distance output logic, which consumes `best_place`.

## Interface
Parameters:
- WIN, 16: window samples per candidate (2..1024).
- RES_LAT, 2: cycles from the last accepted sample to a valid `result` (1..7).
- SEL_MAX, 1: 1 keeps the largest result; 0 keeps the smallest.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- go, in, 1: start-sweep pulse; sampled only in IDLE.
- base, in, 6: first candidate place; latched on an accepted `go`.
- ncand_m1, in, 6: number of candidates minus 1; latched on an accepted `go`.
- pix_rdy, in, 1: the line buffer is presenting a valid f/g pair.
- result, in, 18: topcalcunit result.
- lstart, out, 1: drives unit `lstart`; 1-cycle pulse in LOAD.
- startplace, out, 6: drives unit `startplace`; base+k mod 64.
- startsig, out, 1: high with the first accepted sample of a window.
- work, out, 1: high for the whole of STREAM.
- valid, out, 1: sample-accept strobe to both the unit and the buffer.
- finalstart, out, 1: high with the WIN-th accepted sample.
- change, out, 1: 1-cycle pulse in NEXT.
- busy, out, 1: high from LOAD through DONE.
- done, out, 1: 1-cycle pulse at the end of a sweep.
- best_place, out, 6: winning place.
- best_result, out, 18: winning result.

## Operation
- States:
  - IDLE: `go` → LOAD.
  - LOAD: 1 cycle → STREAM.
  - STREAM: after WIN accepted samples → WAIT.
  - WAIT: RES_LAT cycles → CMP.
  - CMP: 1 cycle → NEXT if k < ncand_m1, else → DONE.
  - NEXT: 1 cycle; k++ → LOAD.
  - DONE: 1 cycle → IDLE.
- `valid` = pix_rdy & (state==STREAM). It is combinational so the buffer pops in the same cycle. All other outputs are registered.
- Sample counter: 10 bits, cleared in LOAD, incremented on `valid`.
  - `startsig` = valid & (cnt==0).
  - `finalstart` = valid & (cnt==WIN-1).
- pix_rdy low in STREAM: stall. `work` stays 1, `valid` is 0, and the counter holds. Stalls have no upper bound.
- `startplace` = (base + k) mod 64. It wraps 63→0 and is held stable from LOAD through CMP.
- CMP update rule:
  - Candidate k=0 always loads `best_result`/`best_place`.
  - Later candidates replace the stored pair only on a strict > (SEL_MAX=1) or strict < (SEL_MAX=0) compare, as unsigned 18-bit values.
  - Ties keep the earlier place.
- `go` while busy is ignored, and `base`/`ncand_m1` changes during a sweep have no effect.
- `best_*` hold their values after DONE until the first CMP of the next sweep.
- `rst` in any state, mid-sweep included: next cycle is IDLE, k=0, cnt=0, and every output is 0 (including `best_place` and `best_result`). No `done` is produced for an aborted sweep.

## Timing
- `go` accepted at cycle 0 (in IDLE). The first LOAD is at cycle 1.
- With pix_rdy held high, the per-candidate period is P = WIN+RES_LAT+3.
  - Candidate k LOAD is at cycle 1+k·P.
  - Its STREAM occupies cycles 2+k·P through 1+k·P+WIN.
- `done` is at cycle n·P, where n = ncand_m1+1. Each stall cycle adds exactly 1 cycle.
- `best_*` are valid in the same cycle as `done`.
- `busy` falls the cycle after `done`. A new `go` is accepted at the earliest in the cycle after `done`.
- Reset values: all outputs 0; state IDLE.

## Test plan
- Defaults, base=10, ncand_m1=3, pix_rdy=1, results per candidate 100/400/250/400 → `startplace` 10,11,12,13; `done` at cycle 84; best_place=11, best_result=400 (tie at place 13 rejected).
- SEL_MAX=0, base=62, ncand_m1=2, results 50/20/20 → `startplace` 62,63,0 (wrap); best_place=63, best_result=20.
- pix_rdy low for 5 cycles after the 3rd accepted sample of candidate 0, ncand_m1=0 → exactly 16 `valid` strobes; `startsig` on the 1st and `finalstart` on the 16th; `work` continuous; `done` at cycle 21+5=26.
- `go` re-pulsed at cycle 30 with base=5 during a sweep started at cycle 0 with base=10 → ignored; `startplace` sequence unchanged; only one `done`.
- `rst` asserted at cycle 40 of a 4-candidate sweep → cycle 41: IDLE, all outputs 0, no `done`. A new `go` at cycle 45 then runs to `done` at cycle 45+84.
- ncand_m1=0 → exactly one `lstart`, zero `change` pulses, `done` at cycle 21.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sweeps candidate disparity places through topcalcunit and keeps the best (result, place).
module calc_seq_ctrl #(
  parameter int WIN     = 16,
  parameter int RES_LAT = 2,
  parameter int SEL_MAX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [5:0]  base,
  input  logic [5:0]  ncand_m1,
  input  logic        pix_rdy,
  input  logic [17:0] result,
  output logic        lstart,
  output logic [5:0]  startplace,
  output logic        startsig,
  output logic        work,
  output logic        valid,
  output logic        finalstart,
  output logic        change,
  output logic        busy,
  output logic        done,
  output logic [5:0]  best_place,
  output logic [17:0] best_result
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, CMP, NEXT, DONE} state_t;
  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [5:0]  k_q, k_d, base_q, base_d, ncand_q, ncand_d, sp_q, sp_d, bpl_q, bpl_d;
  logic [17:0] bres_q, bres_d;
  logic        lstart_q, work_q, change_q, busy_q, done_q, better;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    base_d     = base_q;
    ncand_d    = ncand_q;
    sp_d       = sp_q;
    bpl_d      = bpl_q;
    bres_d     = bres_q;
    valid      = pix_rdy && state_q == STREAM;
    startsig   = valid && cnt_q == 10'd0;
    finalstart = valid && cnt_q == 10'(WIN - 1);
    better     = (SEL_MAX != 0) ? result > bres_q : result < bres_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = LOAD;
        base_d  = base;
        ncand_d = ncand_m1;
        k_d     = 6'd0;
        sp_d    = base;
      end
      LOAD: begin
        state_d = STREAM;
        cnt_d   = 10'd0;
      end
      STREAM: if (valid) begin
        cnt_d   = finalstart ? 10'd0 : cnt_q + 10'd1;
        state_d = finalstart ? WAIT : STREAM;
      end
      // the sample counter is reused to time the result latency
      WAIT: begin
        cnt_d   = (cnt_q == 10'(RES_LAT - 1)) ? 10'd0 : cnt_q + 10'd1;
        state_d = (cnt_q == 10'(RES_LAT - 1)) ? CMP : WAIT;
      end
      CMP: begin
        if (k_q == 6'd0 || better) begin
          bres_d = result;
          bpl_d  = sp_q;
        end
        state_d = (k_q < ncand_q) ? NEXT : DONE;
      end
      NEXT: begin
        k_d     = k_q + 6'd1;
        sp_d    = base_q + k_q + 6'd1;
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      base_q   <= '0;
      ncand_q  <= '0;
      sp_q     <= '0;
      bpl_q    <= '0;
      bres_q   <= '0;
      lstart_q <= 1'b0;
      work_q   <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      base_q   <= base_d;
      ncand_q  <= ncand_d;
      sp_q     <= sp_d;
      bpl_q    <= bpl_d;
      bres_q   <= bres_d;
      lstart_q <= state_d == LOAD;
      work_q   <= state_d == STREAM;
      change_q <= state_d == NEXT;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
    end
  end
  assign lstart      = lstart_q;
  assign startplace  = sp_q;
  assign work        = work_q;
  assign change      = change_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_place  = bpl_q;
  assign best_result = bres_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed sweeps against hand-computed cycle numbers and winners.
module tb_calc_seq_ctrl;
  logic        clk = 0, rst = 1, go = 0, pix_rdy = 0, use1 = 0;
  logic [5:0]  base = 0, ncand_m1 = 0;
  logic [17:0] result = 0;
  logic [37:0] ob0, ob1;
  logic        lstart, startsig, work, valid, finalstart, change, busy, done;
  logic [5:0]  startplace, best_place;
  logic [17:0] best_result;
  int nvec = 0, nerr = 0;
  int res[4];
  int sp[8];
  int nlstart, nchange, nvalid, nwork, ndone, done_cyc, ss, fs, bp, br;

  always #5 clk = ~clk;

  calc_seq_ctrl u0 (.clk(clk), .rst(rst), .go(go), .base(base), .ncand_m1(ncand_m1),
    .pix_rdy(pix_rdy), .result(result), .lstart(ob0[37]), .startplace(ob0[36:31]),
    .startsig(ob0[30]), .work(ob0[29]), .valid(ob0[28]), .finalstart(ob0[27]),
    .change(ob0[26]), .busy(ob0[25]), .done(ob0[24]), .best_place(ob0[23:18]),
    .best_result(ob0[17:0]));
  calc_seq_ctrl #(.SEL_MAX(0)) u1 (.clk(clk), .rst(rst), .go(go), .base(base),
    .ncand_m1(ncand_m1), .pix_rdy(pix_rdy), .result(result), .lstart(ob1[37]),
    .startplace(ob1[36:31]), .startsig(ob1[30]), .work(ob1[29]), .valid(ob1[28]),
    .finalstart(ob1[27]), .change(ob1[26]), .busy(ob1[25]), .done(ob1[24]),
    .best_place(ob1[23:18]), .best_result(ob1[17:0]));
  assign {lstart, startplace, startsig, work, valid, finalstart, change, busy, done,
          best_place, best_result} = use1 ? ob1 : ob0;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " outs"}, int'({lstart, startsig, work, valid, finalstart, change, busy, done}), 0);
    chk({tag, " sp"}, int'(startplace), 0);
    chk({tag, " bp"}, int'(best_place), 0);
    chk({tag, " br"}, int'(best_result), 0);
  endtask

  // t counts cycles from the go pulse; inputs change 1 time unit after each rising edge
  task automatic sweep(input int ncm1, input int b, input int stall_after, input int stall_len,
                       input int rego_at, input int rebase, input int rst_at, input int maxc);
    int stalled = 0;
    nlstart = 0; nchange = 0; nvalid = 0; nwork = 0; ndone = 0;
    done_cyc = -1; ss = -1; fs = -1; bp = -1; br = -1;
    ncand_m1 = 6'(ncm1);
    for (int t = 0; t <= maxc; t++) begin
      go      = (t == 0) || (t == rego_at);
      base    = 6'((t == rego_at) ? rebase : b);
      rst     = (t == rst_at);
      pix_rdy = !(stall_len > 0 && nvalid == stall_after && stalled < stall_len);
      if (!pix_rdy) stalled++;
      result  = 18'((nlstart > 0) ? res[(nlstart - 1) % 4] : 0);
      @(negedge clk);
      if (lstart) begin
        sp[nlstart % 8] = int'(startplace);
        nlstart++;
      end
      if (change) nchange++;
      if (work) nwork++;
      if (valid) begin
        nvalid++;
        if (startsig) ss = nvalid;
        if (finalstart) fs = nvalid;
      end
      if (done) begin
        if (ndone == 0) begin
          done_cyc = t;
          bp = int'(best_place);
          br = int'(best_result);
        end
        ndone++;
      end
      if (rst_at >= 0 && t == rst_at + 1) begin
        chk_zero("midrst");
        nlstart = 0;
      end
      @(posedge clk);
      #1;
    end
    go = 0;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("reset u0");
    use1 = 1;
    #0 chk_zero("reset u1");
    use1 = 0;
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;

    res = '{100, 400, 250, 400};
    sweep(3, 10, 0, 0, -1, 0, -1, 90);
    chk("t1 done", done_cyc, 84);
    chk("t1 ndone", ndone, 1);
    chk("t1 lstarts", nlstart, 4);
    chk("t1 changes", nchange, 3);
    chk("t1 valids", nvalid, 64);
    chk("t1 sp0", sp[0], 10);
    chk("t1 sp3", sp[3], 13);
    chk("t1 bp", bp, 11);
    chk("t1 br", br, 400);
    chk("t1 hold bp", int'(best_place), 11);
    chk("t1 hold br", int'(best_result), 400);
    chk("t1 idle", int'(busy), 0);

    use1 = 1;
    res = '{50, 20, 20, 0};
    sweep(2, 62, 0, 0, -1, 0, -1, 70);
    chk("t2 done", done_cyc, 63);
    chk("t2 sp0", sp[0], 62);
    chk("t2 sp1", sp[1], 63);
    chk("t2 sp2", sp[2], 0);
    chk("t2 bp", bp, 63);
    chk("t2 br", br, 20);
    use1 = 0;

    res = '{7, 0, 0, 0};
    sweep(0, 20, 3, 5, -1, 0, -1, 32);
    chk("t3 valids", nvalid, 16);
    chk("t3 startsig", ss, 1);
    chk("t3 finalstart", fs, 16);
    chk("t3 work", nwork, 21);
    chk("t3 done", done_cyc, 26);

    res = '{100, 400, 250, 400};
    sweep(3, 10, 0, 0, 30, 5, -1, 90);
    chk("t4 ndone", ndone, 1);
    chk("t4 done", done_cyc, 84);
    chk("t4 sp1", sp[1], 11);
    chk("t4 sp2", sp[2], 12);
    chk("t4 sp3", sp[3], 13);

    sweep(3, 10, 0, 0, 45, 10, 40, 135);
    chk("t5 ndone", ndone, 1);
    chk("t5 done", done_cyc, 129);
    chk("t5 bp", bp, 11);
    chk("t5 br", br, 400);

    sweep(0, 33, 0, 0, -1, 0, -1, 26);
    chk("t6 lstarts", nlstart, 1);
    chk("t6 changes", nchange, 0);
    chk("t6 done", done_cyc, 21);
    chk("t6 sp", sp[0], 33);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
